// File: rtl/exe_muldiv_seq.sv
// rtl/exe_muldiv_seq.sv - EXE-stage mul/div iteration sequencer (optional MULDIV_DIVZERO_FAST_EN: single-cycle divide by zero)
module exe_muldiv_seq #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       op_valid_i,
    input  logic       is_mul_i,
    input  logic       is_div_i,
    input  logic       divisor_zero_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       st_e_o,
    output logic       d_init_o,
    output logic       d_advance_o,
    output logic [1:0] mul_state_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start;
    logic             zero_fast;

    assign start = op_valid_i & (is_mul_i | is_div_i) & ~flush_i;

`ifdef MULDIV_DIVZERO_FAST_EN
    // The ALU init path already yields the div-by-zero result, so skip iterating.
    assign zero_fast = divisor_zero_i;
`else
    assign zero_fast = 1'b0 & divisor_zero_i;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_e_o      = 1'b0;
        d_init_o    = 1'b0;
        d_advance_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_e_o = 1'b1;
                    // A simultaneous mul/div decode is resolved as a divide.
                    if (is_div_i) begin
                        d_init_o = 1'b1;
                        if (zero_fast) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_DIV;
                            cnt_d   = DIV_LOAD;
                        end
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = MUL_LOAD;
                    end
                end
            end
            S_MUL: begin
                st_e_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                st_e_o      = 1'b1;
                d_advance_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                if (!hold_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush_i) begin
            st_e_o      = 1'b0;
            d_init_o    = 1'b0;
            d_advance_o = 1'b0;
            done_o      = 1'b0;
            state_d     = S_IDLE;
            cnt_d       = '0;
        end
    end

    assign mul_state_o = state_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// tb/tb_exe_muldiv_seq.sv - randomized bench for exe_muldiv_seq against a cycle-position model
module tb_exe_muldiv_seq;

    localparam int MULC = 2;
    localparam int DIVC = 32;
`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       op_valid = 1'b0, is_mul = 1'b0, is_div = 1'b0, dz = 1'b0, flush = 1'b0, hold = 1'b0;
    logic       st_e, d_init, d_adv, busy, done;
    logic [1:0] ms;

    int vecs = 0;
    int errs = 0;

    exe_muldiv_seq dut (
        .clk(clk), .resetn(resetn), .op_valid_i(op_valid), .is_mul_i(is_mul), .is_div_i(is_div),
        .divisor_zero_i(dz), .flush_i(flush), .hold_i(hold), .st_e_o(st_e), .d_init_o(d_init),
        .d_advance_o(d_adv), .mul_state_o(ms), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {st_e, d_init, d_adv, ms, busy, done};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pos = cycles since start (0 = idle); iterate for pos in 1..len, result at len+1.
    int pos = 0;
    int len = 0;
    bit kdiv = 1'b0;

    always @(negedge clk) begin
        logic [6:0] e;
        bit s;
        e = '0;
        if (!resetn) begin
            pos = 0;
        end else if (pos == 0) begin
            s = op_valid & (is_mul | is_div) & ~flush;
            e[6] = s;
            e[5] = s & is_div;
            if (s) begin
                kdiv = is_div;
                len  = is_div ? ((FAST && dz) ? 0 : DIVC) : MULC;
                pos  = 1;
            end
        end else if (pos <= len) begin
            e[3:2] = kdiv ? 2'd2 : 2'd1;
            e[1]   = 1'b1;
            e[6]   = ~flush;
            e[4]   = kdiv & ~flush;
            pos    = flush ? 0 : pos + 1;
        end else begin
            e[3:2] = 2'd3;
            e[1]   = 1'b1;
            e[0]   = ~flush;
            pos    = (flush || !hold) ? 0 : pos;
        end
        check("model_outputs", int'(outs()), int'(e));
    end

    logic [6:0] lg [0:47];

    function automatic int count_bit(input int b);
        int n = 0;
        for (int c = 0; c < 48; c++) if (lg[c][b]) n++;
        return n;
    endfunction

    function automatic int first_bit(input int b);
        for (int c = 0; c < 48; c++) if (lg[c][b]) return c;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one op at cycle 0 and logs 48 cycles of outputs; entered and left at posedge+1.
    task automatic run_seq(input bit div, input bit zero, input int flush_at, input int hold_from, input int hold_n);
        for (int c = 0; c < 48; c++) begin
            op_valid = (c == 0);
            is_div   = div;
            is_mul   = ~div;
            dz       = zero;
            flush    = (c == flush_at);
            hold     = (c >= hold_from) && (c < hold_from + hold_n);
            #2;
            lg[c] = outs();
            tick();
        end
        {op_valid, is_div, is_mul, dz, flush, hold} = '0;
    endtask

    initial begin
        repeat (3) tick();
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #2 check("reset_idle_outputs", int'(outs()), 0);
            tick();
        end

        run_seq(1'b0, 1'b0, -1, -1, 0);
        check("mul_first_done", first_bit(0), 3);
        check("mul_done_count", count_bit(0), 1);
        check("mul_stall_count", count_bit(6), 3);
        check("mul_state_c1", int'(lg[1][3:2]), 1);
        check("mul_state_c3", int'(lg[3][3:2]), 3);
        check("mul_idle_c4", int'(lg[4][1]), 0);

        run_seq(1'b1, 1'b0, -1, -1, 0);
        check("div_init_count", count_bit(5), 1);
        check("div_init_c0", int'(lg[0][5]), 1);
        check("div_adv_count", count_bit(4), 32);
        check("div_first_adv", first_bit(4), 1);
        check("div_first_done", first_bit(0), 33);
        check("div_stall_count", count_bit(6), 33);

        run_seq(1'b1, 1'b0, 10, -1, 0);
        check("flush_stall_c10", int'(lg[10][6]), 0);
        check("flush_busy_c11", int'(lg[11][1]), 0);
        check("flush_no_done", count_bit(0), 0);
        run_seq(1'b0, 1'b0, -1, -1, 0);
        check("post_flush_mul_done", first_bit(0), 3);

        run_seq(1'b0, 1'b0, -1, 3, 3);
        check("hold_done_count", count_bit(0), 4);
        check("hold_state_c6", int'(lg[6][3:2]), 3);
        check("hold_idle_c7", int'(lg[7][1]), 0);
        check("hold_no_restart", count_bit(6), 3);

        run_seq(1'b1, 1'b1, -1, -1, 0);
        check("dz_init_c0", int'(lg[0][5]), 1);
        check("dz_first_done", first_bit(0), FAST ? 1 : 33);
        check("dz_adv_count", count_bit(4), FAST ? 0 : 32);

        // Reset pulled mid-divide must drop everything at once.
        op_valid = 1'b1; is_div = 1'b1;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        #1 check("async_reset_outputs", int'(outs()), 0);
        tick();
        resetn = 1'b1;
        is_div = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            op_valid = ($urandom_range(0, 9) < 6);
            is_mul   = $urandom_range(0, 1);
            is_div   = $urandom_range(0, 1);
            dz       = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            hold     = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 299) == 0) begin
                {op_valid, is_mul, is_div, dz, flush, hold} = '0;
                resetn = 1'b0;
            end else begin
                resetn = 1'b1;
            end
            tick();
        end
        resetn = 1'b1;
        {op_valid, is_mul, is_div, dz, flush, hold} = '0;
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
